// File: rtl/pipe_stage_buffer.sv
// rtl/pipe_stage_buffer.sv - two-entry skid buffer pipeline stage; optional macro PIPE_STAGE_BUFFER_CLR_DATA_EN zeroes payload on flush
module pipe_stage_buffer #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready,
    output logic [1:0]        occupancy
);

    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_ONE   = 2'd1;
    localparam logic [1:0] ST_FULL  = 2'd2;

    logic [1:0]        state;
    logic [1:0]        state_nxt;
    logic [DATA_W-1:0] head;
    logic [DATA_W-1:0] head_nxt;
    logic [DATA_W-1:0] skid;
    logic [DATA_W-1:0] skid_nxt;
    logic              accept;
    logic              pop;

    assign accept = in_valid & in_ready;
    assign pop    = out_valid & out_ready;

    always_comb begin
        state_nxt = state;
        head_nxt  = head;
        skid_nxt  = skid;
        case (state)
            ST_EMPTY: begin
                if (accept) begin
                    state_nxt = ST_ONE;
                    head_nxt  = in_data;
                end
            end
            ST_ONE: begin
                if (accept && pop) begin
                    head_nxt = in_data;
                end else if (accept) begin
                    state_nxt = ST_FULL;
                    skid_nxt  = in_data;
                end else if (pop) begin
                    state_nxt = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (pop) begin
                    state_nxt = ST_ONE;
                    head_nxt  = skid;
                end
            end
            default: state_nxt = ST_EMPTY;
        endcase
        // flush wins over any accept or pop on the same edge
        if (flush) begin
            state_nxt = ST_EMPTY;
`ifdef PIPE_STAGE_BUFFER_CLR_DATA_EN
            head_nxt  = '0;
            skid_nxt  = '0;
`else
            head_nxt  = head;
            skid_nxt  = skid;
`endif
        end
    end

    // handshake flags are decoded from the next state so they leave a flop
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_EMPTY;
            head      <= '0;
            skid      <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            state     <= state_nxt;
            head      <= head_nxt;
            skid      <= skid_nxt;
            in_ready  <= (state_nxt != ST_FULL);
            out_valid <= (state_nxt != ST_EMPTY);
        end
    end

    assign out_data  = head;
    assign occupancy = state;

endmodule
